// File: rtl/sram_access_ctrl.sv
// Single-port SRAM access controller with fixed-latency word accesses.
// Optional zero-fill sequence enabled by defining SRAM_CLEAR_EN.
module sram_access_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 512,
  parameter int ACCESS_LAT = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wen,
  input  logic              ren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear_mem,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        sram_state
);

  localparam int MA_W  = $clog2(DEPTH);
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_FREE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_wr;
  logic [MA_W-1:0]   r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_oob;
  logic              w_last;
  logic              w_start;
  logic              w_clr_go;
  logic              w_clr_act;
  logic              w_mem_we;
  logic [MA_W-1:0]   w_mem_a;
  logic [DATA_W-1:0] w_mem_d;

`ifdef SRAM_CLEAR_EN
  logic r_clr;
  assign w_clr_go  = clear_mem;
  assign w_clr_act = r_clr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_clr <= 1'b0;
    end else if (r_state == S_FREE) begin
      r_clr <= clear_mem;
    end
  end
`else
  logic w_unused;
  assign w_unused  = clear_mem;
  assign w_clr_go  = 1'b0;
  assign w_clr_act = 1'b0;
`endif

  assign w_oob = {1'b0, addr} >= (ADDR_W+1)'(DEPTH);

  assign w_last = w_clr_act
                ? (r_cnt == CNT_W'(DEPTH-1))
                : (r_cnt == CNT_W'(ACCESS_LAT-1));

  assign w_start = (r_state == S_FREE) && !w_clr_go
                && (wen ^ ren) && !w_oob;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_FREE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FREE: begin
        if (w_clr_go)          w_next = S_BUSY;
        else if (wen && ren)   w_next = S_ERR;
        else if (wen ^ ren)    w_next = w_oob ? S_ERR : S_BUSY;
      end
      S_BUSY: if (w_last)      w_next = S_DONE;
      S_DONE:                  w_next = S_FREE;
      S_ERR:                   w_next = S_FREE;
      default:                 w_next = S_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      rdata   <= '0;
    end else if (r_state == S_FREE) begin
      r_cnt <= '0;
      if (w_start) begin
        r_wr    <= wen;
        r_addr  <= addr[MA_W-1:0];
        r_wdata <= wdata;
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last && !w_clr_act && !r_wr) rdata <= r_mem[r_addr];
    end
  end

  // Zero-fill walks the counter as the address; gated by n_rst so an
  // aborted access never lands in the array.
  assign w_mem_we = n_rst && (r_state == S_BUSY)
                 && (w_clr_act || (w_last && r_wr));
  assign w_mem_a  = w_clr_act ? r_cnt[MA_W-1:0] : r_addr;
  assign w_mem_d  = w_clr_act ? '0 : r_wdata;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_a] <= w_mem_d;
  end

  assign sram_state = r_state;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl: directed ops push expected
// DONE/ERROR responses, a negedge monitor pops and compares them.
module tb_sram_access_ctrl;
  localparam int LAT   = 2;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic        clear_mem = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [1:0]  sram_state;

  int checks = 0;
  int failures = 0;
  int dones = 0;
  int exp_dones = 0;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] rd;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mrd = '0;

  always #5 clk = ~clk;

  sram_access_ctrl #(
    .ADDR_W(10), .DATA_W(32), .DEPTH(DEPTH), .ACCESS_LAT(LAT)
  ) dut (
    .clk(clk), .n_rst(n_rst), .wen(wen), .ren(ren),
    .addr(addr), .wdata(wdata), .clear_mem(clear_mem),
    .rdata(rdata), .sram_state(sram_state)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst && sram_state[1]) begin
      if (sram_state == 2'b10) dones++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%0d required=none",
                 sram_state);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_state", 32'(sram_state), 32'(mon_e.st));
        chk("resp_rdata", rdata, mon_e.rd);
      end
    end
  end

  task automatic op(input logic w, input logic r,
                    input logic [9:0] a, input logic [31:0] d,
                    input logic [31:0] erd, input string nm);
    bit err;
    err = (w && r) || (int'(a) >= DEPTH);
    @(posedge clk); #1;
    wen = w; ren = r; addr = a; wdata = d;
    if (!err && r) mrd = erd;
    if (err) begin
      sbq.push_back('{st: 2'b11, rd: mrd});
    end else begin
      sbq.push_back('{st: 2'b10, rd: mrd});
      exp_dones++;
    end
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0;
    if (err) begin
      @(negedge clk); chk({nm, "_err"}, 32'(sram_state), 32'd3);
      @(negedge clk); chk({nm, "_free"}, 32'(sram_state), 32'd0);
    end else begin
      for (int i = 0; i < LAT; i++) begin
        @(negedge clk); chk({nm, "_busy"}, 32'(sram_state), 32'd1);
      end
      @(negedge clk); chk({nm, "_done"}, 32'(sram_state), 32'd2);
      @(negedge clk); chk({nm, "_free"}, 32'(sram_state), 32'd0);
    end
  endtask

  initial begin
    int d0;
    int nb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(sram_state), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    n_rst = 1'b1;

    op(1, 0, 10'd5, 32'hDEADBEEF, 0, "t1_wr5");
    op(0, 1, 10'd5, 0, 32'hDEADBEEF, "t2_rd5");
    repeat (10) @(negedge clk);
    chk("t2_hold", rdata, 32'hDEADBEEF);

    op(1, 0, 10'd7, 32'h7777_7777, 0, "t3_wr7");
    op(1, 1, 10'd7, 32'h0000_0BAD, 0, "t3_both");
    chk("t3_rdata", rdata, 32'hDEADBEEF);
    op(0, 1, 10'd7, 0, 32'h7777_7777, "t3_rd7");

    op(1, 0, 10'd88, 32'h0BAD_F00D, 0, "t4_wr88");
    op(1, 0, 10'd600, 32'hCAFE_F00D, 0, "t4_oob");
    op(0, 1, 10'd88, 0, 32'h0BAD_F00D, "t4_rd88");

    d0 = dones;
    @(posedge clk); #1;
    wen = 1'b1; addr = 10'd0; wdata = 32'h1111_2222;
    sbq.push_back('{st: 2'b10, rd: mrd});
    sbq.push_back('{st: 2'b10, rd: mrd});
    exp_dones += 2;
    repeat (3) @(posedge clk);
    #1;
    addr = 10'd1; wdata = 32'h3333_4444;
    repeat (2) @(posedge clk);
    #1;
    wen = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_free", 32'(sram_state), 32'd0);
    chk("t5_pulses", 32'(dones - d0), 32'd2);
    op(0, 1, 10'd0, 0, 32'h1111_2222, "t5_rd0");
    op(0, 1, 10'd1, 0, 32'h3333_4444, "t5_rd1");

    op(1, 0, 10'd9, 32'h1234_5678, 0, "t6_wr9");
    @(posedge clk); #1;
    wen = 1'b1; addr = 10'd9; wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    wen = 1'b0;
    chk("t6_busy", 32'(sram_state), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("t6_rst_state", 32'(sram_state), 32'd0);
    chk("t6_rst_rdata", rdata, 32'd0);
    mrd = '0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    op(0, 1, 10'd9, 0, 32'h1234_5678, "t6_rd9");

`ifdef SRAM_CLEAR_EN
    op(1, 0, 10'd3, 32'hA5A5_A5A5, 0, "t7_wr3");
    @(posedge clk); #1;
    clear_mem = 1'b1;
    sbq.push_back('{st: 2'b10, rd: mrd});
    exp_dones++;
    @(posedge clk); #1;
    clear_mem = 1'b0;
    nb = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sram_state != 2'b01) break;
      nb++;
    end
    chk("t7_busy_len", 32'(nb), 32'd512);
    chk("t7_done", 32'(sram_state), 32'd2);
    @(negedge clk);
    chk("t7_free", 32'(sram_state), 32'd0);
    op(0, 1, 10'd3, 0, 32'h0, "t7_rd3");
`else
    nb = 0;
    @(posedge clk); #1;
    clear_mem = 1'b1;
    @(posedge clk); #1;
    clear_mem = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sram_state != 2'b00) nb++;
    end
    chk("t7_idle", 32'(nb), 32'd0);
    op(0, 1, 10'd5, 0, 32'hDEADBEEF, "t7_rd5");
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("done_count", 32'(dones), 32'(exp_dones));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
